alu_scheduler: RTL and testbench
================================

# alu_scheduler

Round-robin scheduler that shares one WIDTH-bit ALU datapath between NUM_REQ requesters. Each requester offers an operand pair and opcode over a valid/ready handshake. The block grants one request at a time, executes it on a registered ALU stage, and returns the result with the winner's ID over a valid/ready response channel. It sits between the requesting control units and the shared ALU core.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/result width in bits
- IDW, $clog2(NUM_REQ), requester ID width (derived localparam)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  grant; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- req_op  in  NUM_REQ*3  opcode; requester i in bits [i*3 +: 3]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  ALU result
- rsp_id  out  IDW  index of the requester that owns rsp_data
- busy  out  1  high in every state other than IDLE

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - If any req_valid bit is set, select grant g as the first set bit at or above ptr, wrapping modulo NUM_REQ.
  - Drive req_ready[g]=1 combinationally for that cycle only. The handshake completes on that edge.
  - Latch a, b, op and g. Next state is EXEC.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- EXEC (one cycle):
  - alu_core evaluates the latched operands.
  - At the edge, register rsp_data and rsp_id and set rsp_valid=1. Next state is RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_valid&rsp_ready.
  - On that handshake: clear rsp_valid, set ptr=(g+1) mod NUM_REQ, return to IDLE.
- Opcodes, computed modulo 2^WIDTH:
  - 000 A+B
  - 001 A−B, two's-complement wrap
  - 010 A&B
  - 011 A|B
  - 100 ~A (B ignored)
  - 101–111 result 0
- req_ready is 0 in EXEC and RESP. Requests raised in those states wait and are not dropped.
- A requester that deasserts req_valid before it is granted is simply skipped.
- ptr wraps from NUM_REQ−1 to 0. With every requester continuously valid, grants rotate 0,1,…,NUM_REQ−1,0.
- Reset mid-operation aborts any in-flight op. No response is ever produced for it.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. With ALU_FLAGS_EN: rsp_carry=0, rsp_zero=0.
- Request accepted at edge k → rsp_valid high after edge k+1.
- If rsp_ready=1 at edge k+2, the next grant can occur at edge k+3.
- Peak throughput is one operation per 3 cycles.
- rsp_ready is ignored outside RESP.
- The response is sampled only when rsp_valid=1.
- req_ready depends combinationally on req_valid and state, never on rsp_ready.

## Configuration
- ALU_FLAGS_EN defined:
  - Adds outputs rsp_carry (1 bit) and rsp_zero (1 bit), registered alongside rsp_data.
  - rsp_carry is the carry-out for 000 and the borrow for 001 (A<B unsigned). It is 0 for all other opcodes.
  - rsp_zero=1 when rsp_data==0.
- ALU_FLAGS_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Package alu_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP
- Sub-module alu_core:
  - purely combinational, parameter WIDTH
  - inputs a, b, op; outputs y and carry
  - the scheduler instantiates exactly one
- The round-robin priority pick stays inline in alu_scheduler.

## Test plan
All scenarios use NUM_REQ=4, WIDTH=4.
- Reset: hold rst_n=0 with req_valid=4'b1111 → req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
- Single request: req 2 sends A=0101, B=0011, op=000, rsp_ready=1 → grant req_ready=0100; rsp_valid two edges after grant with rsp_data=1000, rsp_id=2.
- Wrap and opcodes:
  - A=1000, B=0011, op=001 → 0101.
  - A=0011, B=0101, op=001 → 1110 (carry=1 with ALU_FLAGS_EN).
  - A=1111, B=0001, op=000 → 0000 (zero=1, carry=1).
  - op=100 with A=1001 → 0110.
  - op=111 → 0000.
- Round-robin: req_valid=1111 held, rsp_ready=1 → rsp_id sequence 0,1,2,3,0; never two grants within 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; grant resumes the cycle after rsp_ready=1.
- Mid-op reset: assert rst_n=0 during EXEC → no rsp_valid after release; the next grant goes to requester 0 (ptr reset).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU scheduler slice.
//   - ALU opcode encodings (3 bits)
//   - scheduler FSM state encodings (2 bits)
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational WIDTH-bit ALU.
// Ports:
//   a, b   in  WIDTH  operands
//   op     in  3      opcode (alu_pkg OP_*); undefined opcodes yield 0
//   y      out WIDTH  result, modulo 2^WIDTH
//   carry  out 1      carry-out for ADD, borrow (a < b unsigned) for SUB, else 0
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // One extra bit: the MSB is the carry for the sum and the borrow for the difference.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  {carry, y} = w_sum;
      OP_SUB:  {carry, y} = w_diff;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter sharing one registered ALU stage
// between NUM_REQ requesters.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              packed opcodes, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready response handshake
//   rsp_data, rsp_id    ALU result and owning requester index
//   busy                high whenever the FSM is not idle
// Optional feature macro ALU_FLAGS_EN adds rsp_carry and rsp_zero outputs.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
`ifdef ALU_FLAGS_EN
  output logic                     rsp_carry,
  output logic                     rsp_zero,
`endif
  output logic                     busy
);

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_gnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
`ifdef ALU_FLAGS_EN
  logic             r_rsp_carry;
  logic             r_rsp_zero;
`endif

  logic [WIDTH-1:0] w_a_arr  [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr  [NUM_REQ];
  logic [2:0]       w_op_arr [NUM_REQ];
  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
    assign w_op_arr[gi] = req_op[gi*3 +: 3];
  end

  // Round-robin pick: first valid requester at or above r_ptr, wrapping.
  // One spare bit on the sum keeps the wrap correct for non-power-of-2 NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Gated by rst_n so no grant is offered while reset is held.
  assign w_accept = rst_n && (r_state == ST_IDLE) && w_found;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_pick] = 1'b1;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a     (r_a),
    .b     (r_b),
    .op    (r_op),
    .y     (w_y),
    .carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
`ifdef ALU_FLAGS_EN
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_a     <= w_a_arr[w_pick];
            r_b     <= w_b_arr[w_pick];
            r_op    <= w_op_arr[w_pick];
            r_gnt   <= w_pick;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_y;
          r_rsp_id    <= r_gnt;
`ifdef ALU_FLAGS_EN
          r_rsp_carry <= w_carry;
          r_rsp_zero  <= (w_y == '0);
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_gnt == IDW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);

`ifdef ALU_FLAGS_EN
  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed bench for alu_scheduler (NUM_REQ=4, WIDTH=4).
// Expected responses come from a bench-side ALU/round-robin model and are
// queued at grant time, then popped when rsp_valid appears.
// Honours ALU_FLAGS_EN when defined.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef ALU_FLAGS_EN
  logic        rsp_carry;
  logic        rsp_zero;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ma  [4];
  logic [3:0] mb  [4];
  logic [2:0] mop [4];
  logic [1:0] model_ptr;
  int         n_pass  = 0;
  int         n_total = 0;

  alu_scheduler #(
    .NUM_REQ (4),
    .WIDTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef ALU_FLAGS_EN
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not reach the summary");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [1:0] id);
    logic [4:0] s;
    exp_t       e;
    e.id    = id;
    e.carry = 1'b0;
    case (mop[id])
      3'd0: begin s = 5'(ma[id]) + 5'(mb[id]); e.data = s[3:0]; e.carry = s[4]; end
      3'd1: begin e.data = ma[id] - mb[id]; e.carry = (ma[id] < mb[id]); end
      3'd2: e.data = ma[id] & mb[id];
      3'd3: e.data = ma[id] | mb[id];
      3'd4: e.data = ~ma[id];
      default: e.data = 4'h0;
    endcase
    e.zero = (e.data == 4'h0);
    return e;
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] p);
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
      c = p + 2'(k);
      if (m[c]) return c;
    end
    return 2'd0;
  endfunction

  task automatic set_req(input logic [1:0] i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    ma[i]  = a;
    mb[i]  = b;
    mop[i] = op;
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after
  // the response handshake, DUT back in IDLE.
  task automatic serve(input logic [3:0] mask, input int hold);
    logic [1:0] g;
    exp_t       e;
    int         lat;
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    g = pick(mask, model_ptr);
    check("grant", 32'(req_ready), 32'(4'b0001 << g));
    check("busy_idle", 32'(busy), 0);
    sb.push_back(model(g));
    @(negedge clk);
    lat = 1;
    check("ready_exec", 32'(req_ready), 0);
    check("busy_exec", 32'(busy), 1);
    check("early_rsp", 32'(rsp_valid), 0);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), 2);
    if (!rsp_valid) begin
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check("rsp_data", 32'(rsp_data), 32'(e.data));
    check("rsp_id", 32'(rsp_id), 32'(e.id));
`ifdef ALU_FLAGS_EN
    check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
    check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
`endif
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", 32'(rsp_data), 32'(e.data));
      check("hold_id", 32'(rsp_id), 32'(e.id));
      check("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_clear", 32'(rsp_valid), 0);
    model_ptr = g + 2'd1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    model_ptr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ma[i] = 4'h0; mb[i] = 4'h0; mop[i] = 3'd0;
    end

    // Reset held with every requester valid
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef ALU_FLAGS_EN
    check("rst_carry", 32'(rsp_carry), 0);
    check("rst_zero", 32'(rsp_zero), 0);
`endif
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(negedge clk);
    check("idle_noreq_ready", 32'(req_ready), 0);

    // Single request from requester 2: 5 + 3 = 8
    set_req(2'd2, 4'b0101, 4'b0011, 3'b000);
    serve(4'b0100, 0);

    // Opcode coverage; last op on requester 3 wraps ptr back to 0
    set_req(2'd1, 4'b1000, 4'b0011, 3'b001);  serve(4'b0010, 0);
    set_req(2'd3, 4'b0011, 4'b0101, 3'b001);  serve(4'b1000, 0);
    set_req(2'd0, 4'b1111, 4'b0001, 3'b000);  serve(4'b0001, 0);
    set_req(2'd1, 4'b1001, 4'b0110, 3'b100);  serve(4'b0010, 0);
    set_req(2'd2, 4'b0111, 4'b0111, 3'b111);  serve(4'b0100, 0);
    set_req(2'd2, 4'b1100, 4'b1010, 3'b010);  serve(4'b0100, 0);
    set_req(2'd3, 4'b1100, 4'b1010, 3'b011);  serve(4'b1000, 0);

    // Round-robin with all requesters held valid: ids 0,1,2,3,0
    set_req(2'd0, 4'b0001, 4'b0010, 3'b000);
    set_req(2'd1, 4'b0110, 4'b0011, 3'b001);
    set_req(2'd2, 4'b1010, 4'b0110, 3'b010);
    set_req(2'd3, 4'b0000, 4'b0000, 3'b100);
    repeat (5) serve(4'b1111, 0);

    // Backpressure: 5 cycles of rsp_ready=0 in RESP
    set_req(2'd1, 4'b0110, 4'b1001, 3'b000);
    serve(4'b0010, 5);

    // Mid-op reset: ptr is 2 here, abort requester 2 during EXEC
    set_req(2'd2, 4'b0001, 4'b0001, 3'b000);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("midrst_grant", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    check("midrst_busy", 32'(busy), 1);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("midrst_valid", 32'(rsp_valid), 0);
    check("midrst_busy_clr", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 0);
    end
    model_ptr = 2'd0;
    serve(4'b1111, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
